// File: rtl/seq_packer_pp.sv
// Double-buffered sequence packer: input FIFO feeding two ping-pong packet buffers of PACKET_SIZE lanes.
// Optional idle-timeout flush of partial packets is compiled in with `define SEQ_PACKER_TIMEOUT_EN.
module seq_packer_pp #(
    parameter int PACKET_SIZE = 4,
    parameter int LL_BITS     = 17,
    parameter int ML_BITS     = 17,
    parameter int OFFSET_BITS = 17,
    parameter int FIFO_DEPTH  = 8,
    parameter int TIMEOUT     = 64
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               i_valid,
    input  logic [LL_BITS-1:0]                 i_ll,
    input  logic [ML_BITS-1:0]                 i_ml,
    input  logic [OFFSET_BITS-1:0]             i_offset,
    input  logic                               i_eoj,
    input  logic [ML_BITS-1:0]                 i_overlap_len,
    input  logic                               i_delim,
    output logic                               i_ready,
    output logic                               o_valid,
    output logic [PACKET_SIZE-1:0]             o_mask,
    output logic [$clog2(PACKET_SIZE+1)-1:0]   o_count,
    output logic [PACKET_SIZE*LL_BITS-1:0]     o_ll,
    output logic [PACKET_SIZE*ML_BITS-1:0]     o_ml,
    output logic [PACKET_SIZE*OFFSET_BITS-1:0] o_offset,
    output logic [ML_BITS-1:0]                 o_overlap,
    output logic                               o_eoj,
    output logic                               o_delim,
    input  logic                               o_ready
);

    localparam int CW = $clog2(PACKET_SIZE + 1);
    localparam int IW = $clog2(PACKET_SIZE);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int FW = $clog2(FIFO_DEPTH + 1);
    localparam int EW = LL_BITS + ML_BITS + OFFSET_BITS + ML_BITS + 2;

    if (PACKET_SIZE < 2 || (PACKET_SIZE & (PACKET_SIZE - 1)) != 0 || TIMEOUT < 1 || FIFO_DEPTH < 2)
    begin : g_param_check
        $error("seq_packer_pp: illegal parameter combination");
    end

    typedef enum logic [1:0] {BUF_EMPTY, BUF_FILLING, BUF_CLOSED} buf_state_t;

    function automatic logic [PACKET_SIZE-1:0] therm(input logic [CW-1:0] n);
        logic [PACKET_SIZE-1:0] t;
        for (int i = 0; i < PACKET_SIZE; i++) t[i] = (i < int'(n));
        return t;
    endfunction

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Input FIFO
    logic [EW-1:0]  fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [FW-1:0]  fifo_cnt;
    logic           push, pop, fifo_o_valid, fifo_o_ready;
    logic [LL_BITS-1:0]     h_ll;
    logic [ML_BITS-1:0]     h_ml, h_ovl;
    logic [OFFSET_BITS-1:0] h_off;
    logic                   h_eoj, h_delim;

    assign i_ready      = (fifo_cnt != FW'(FIFO_DEPTH));
    assign push         = i_valid && i_ready;
    assign fifo_o_valid = (fifo_cnt != '0);
    assign pop          = fifo_o_valid && fifo_o_ready;
    assign {h_ll, h_ml, h_off, h_ovl, h_eoj, h_delim} = fifo_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= {i_ll, i_ml, i_offset, i_overlap_len, i_eoj, i_delim};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            if (push && !pop)      fifo_cnt <= fifo_cnt + 1'b1;
            else if (!push && pop) fifo_cnt <= fifo_cnt - 1'b1;
        end
    end

    // Ping-pong packet buffers
    buf_state_t             buf_state [2];
    logic [LL_BITS-1:0]     ll_q  [2][PACKET_SIZE];
    logic [ML_BITS-1:0]     ml_q  [2][PACKET_SIZE];
    logic [OFFSET_BITS-1:0] off_q [2][PACKET_SIZE];
    logic [ML_BITS-1:0]     ovl_q  [2];
    logic                   eoj_q  [2];
    logic                   delim_q[2];
    logic [CW-1:0]          cnt_q  [2];
    logic [PACKET_SIZE-1:0] mask_q [2];
    logic                   fill_sel, drain_sel;
    logic [IW-1:0]          idx;
    logic                   load_close, to_close, fill_close, release_pkt;
    logic [CW-1:0]          close_cnt;

    assign fifo_o_ready = (buf_state[fill_sel] != BUF_CLOSED);
    assign load_close   = pop && ((idx == IW'(PACKET_SIZE - 1)) || h_eoj || h_delim);
    assign fill_close   = load_close || to_close;
    // A timeout close has no load in the same cycle, so idx already equals the lane count
    assign close_cnt    = pop ? CW'(idx) + 1'b1 : CW'(idx);
    assign release_pkt  = o_valid && o_ready;

`ifdef SEQ_PACKER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] idle_cnt;

    assign to_close = !pop && (buf_state[fill_sel] == BUF_FILLING) && (idle_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst_n || pop || fill_close)             idle_cnt <= '0;
        else if (buf_state[fill_sel] == BUF_FILLING) idle_cnt <= idle_cnt + 1'b1;
    end
`else
    assign to_close = 1'b0;
`endif

    // Fill and drain buffers never coincide while both are active, so the writes below are disjoint
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fill_sel  <= 1'b0;
            drain_sel <= 1'b0;
            idx       <= '0;
            for (int b = 0; b < 2; b++) begin
                buf_state[b] <= BUF_EMPTY;
                ovl_q[b]     <= '0;
                eoj_q[b]     <= 1'b0;
                delim_q[b]   <= 1'b0;
                cnt_q[b]     <= '0;
                mask_q[b]    <= '0;
                for (int i = 0; i < PACKET_SIZE; i++) begin
                    ll_q[b][i]  <= '0;
                    ml_q[b][i]  <= '0;
                    off_q[b][i] <= '0;
                end
            end
        end else begin
            if (release_pkt) begin
                buf_state[drain_sel] <= BUF_EMPTY;
                ovl_q[drain_sel]     <= '0;
                eoj_q[drain_sel]     <= 1'b0;
                delim_q[drain_sel]   <= 1'b0;
                cnt_q[drain_sel]     <= '0;
                mask_q[drain_sel]    <= '0;
                for (int i = 0; i < PACKET_SIZE; i++) begin
                    ll_q[drain_sel][i]  <= '0;
                    ml_q[drain_sel][i]  <= '0;
                    off_q[drain_sel][i] <= '0;
                end
                drain_sel <= ~drain_sel;
            end
            if (pop) begin
                ll_q[fill_sel][idx]  <= h_ll;
                ml_q[fill_sel][idx]  <= h_ml;
                off_q[fill_sel][idx] <= h_off;
                ovl_q[fill_sel]      <= h_ovl;
                eoj_q[fill_sel]      <= h_eoj;
                delim_q[fill_sel]    <= h_delim;
            end
            if (fill_close) begin
                buf_state[fill_sel] <= BUF_CLOSED;
                cnt_q[fill_sel]     <= close_cnt;
                mask_q[fill_sel]    <= therm(close_cnt);
                fill_sel            <= ~fill_sel;
                idx                 <= '0;
            end else if (pop) begin
                buf_state[fill_sel] <= BUF_FILLING;
                idx                 <= idx + 1'b1;
            end
        end
    end

    always_comb begin
        o_valid   = (buf_state[drain_sel] == BUF_CLOSED);
        o_mask    = mask_q[drain_sel];
        o_count   = cnt_q[drain_sel];
        o_overlap = ovl_q[drain_sel];
        o_eoj     = eoj_q[drain_sel];
        o_delim   = delim_q[drain_sel];
        o_ll      = '0;
        o_ml      = '0;
        o_offset  = '0;
        for (int i = 0; i < PACKET_SIZE; i++) begin
            o_ll[i*LL_BITS +: LL_BITS]             = ll_q[drain_sel][i];
            o_ml[i*ML_BITS +: ML_BITS]             = ml_q[drain_sel][i];
            o_offset[i*OFFSET_BITS +: OFFSET_BITS] = off_q[drain_sel][i];
        end
    end

endmodule

// File: tb/tb_seq_packer_pp.sv
// Testbench for seq_packer_pp: table of sequences with expected packet shape, scoreboard queue of packets.
module tb_seq_packer_pp;

    localparam int PS = 4;
    localparam int W  = 17;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             i_valid;
    logic [W-1:0]     i_ll, i_ml, i_offset, i_overlap_len;
    logic             i_eoj, i_delim, i_ready;
    logic             o_valid;
    logic [PS-1:0]    o_mask;
    logic [2:0]       o_count;
    logic [PS*W-1:0]  o_ll, o_ml, o_offset;
    logic [W-1:0]     o_overlap;
    logic             o_eoj, o_delim, o_ready;

    always #5 clk = ~clk;

    seq_packer_pp dut (
        .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_ll(i_ll), .i_ml(i_ml), .i_offset(i_offset),
        .i_eoj(i_eoj), .i_overlap_len(i_overlap_len), .i_delim(i_delim), .i_ready(i_ready),
        .o_valid(o_valid), .o_mask(o_mask), .o_count(o_count), .o_ll(o_ll), .o_ml(o_ml),
        .o_offset(o_offset), .o_overlap(o_overlap), .o_eoj(o_eoj), .o_delim(o_delim), .o_ready(o_ready)
    );

    typedef struct {
        logic [W-1:0] ll, ml, off, ovl;
        logic         eoj, delim, close;
        logic [3:0]   exp_mask;
        logic [2:0]   exp_cnt;
    } vec_t;

    typedef struct {
        logic [3:0]    mask;
        logic [2:0]    cnt;
        logic [PS*W-1:0] ll, ml, off;
        logic [W-1:0]  ovl;
        logic          eoj, delim;
    } pkt_t;

    pkt_t exp_q[$];
    pkt_t cur;
    int   cur_n = 0;
    int   checks = 0, errors = 0;
    int   cycle = 0, accepted = 0, stalls = 0, valid_seen = 0;
    int   rel_cycle[$];
    vec_t tbl[14];

    logic            stalled = 1'b0;
    logic [PS*W-1:0] held_ll, held_ml, held_off;
    logic [3:0]      held_mask;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic vec_t mk(input int ll, input int ml, input int off, input int ovl,
                                input logic eoj, input logic delim, input logic close,
                                input logic [3:0] m, input logic [2:0] c);
        vec_t v;
        v.ll = W'(ll); v.ml = W'(ml); v.off = W'(off); v.ovl = W'(ovl);
        v.eoj = eoj; v.delim = delim; v.close = close; v.exp_mask = m; v.exp_cnt = c;
        return v;
    endfunction

    function automatic pkt_t empty_pkt();
        pkt_t p;
        p.mask = '0; p.cnt = '0; p.ll = '0; p.ml = '0; p.off = '0;
        p.ovl = '0; p.eoj = 1'b0; p.delim = 1'b0;
        return p;
    endfunction

    task automatic model_accept(input vec_t v);
        accepted++;
        cur.ll[cur_n*W +: W]  = v.ll;
        cur.ml[cur_n*W +: W]  = v.ml;
        cur.off[cur_n*W +: W] = v.off;
        cur_n++;
        if (v.close) begin
            cur.mask = v.exp_mask; cur.cnt = v.exp_cnt;
            cur.ovl = v.ovl; cur.eoj = v.eoj; cur.delim = v.delim;
            exp_q.push_back(cur);
            cur = empty_pkt();
            cur_n = 0;
        end
    endtask

    task automatic send(input vec_t v);
        int   waitc = 0;
        logic acc;
        i_valid = 1'b1; i_ll = v.ll; i_ml = v.ml; i_offset = v.off;
        i_overlap_len = v.ovl; i_eoj = v.eoj; i_delim = v.delim;
        do begin
            acc = i_ready;
            @(posedge clk); #1;
            waitc++;
        end while (!acc && waitc < 200);
        i_valid = 1'b0;
        if (waitc > 1) stalls++;
        if (!acc) begin
            checks++; errors++;
            $display("FAIL send_accept actual=not_accepted required=accepted ll=%0d", v.ll);
        end else begin
            model_accept(v);
        end
    endtask

    task automatic wait_drain(input int limit);
        int n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            @(posedge clk); #1;
            n++;
        end
        chk("queue_drained", exp_q.size(), 0);
    endtask

    // Output monitor: scoreboard pop on release, stability check while stalled
    always @(negedge clk) begin
        if (rst_n && o_valid) valid_seen++;
        if (rst_n && o_valid && stalled) begin
            chk("stall_hold_ll", o_ll, held_ll);
            chk("stall_hold_ml", o_ml, held_ml);
            chk("stall_hold_off", o_offset, held_off);
            chk("stall_hold_mask", o_mask, held_mask);
        end
        stalled   = rst_n && o_valid && !o_ready;
        held_ll   = o_ll;  held_ml = o_ml;  held_off = o_offset;  held_mask = o_mask;
        if (rst_n && o_valid && o_ready) begin
            rel_cycle.push_back(cycle);
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_pkt actual=packet mask=%0h required=no_packet", o_mask);
            end else begin
                pkt_t e;
                e = exp_q.pop_front();
                chk("pkt_mask", o_mask, e.mask);
                chk("pkt_count", o_count, e.cnt);
                chk("pkt_ll", o_ll, e.ll);
                chk("pkt_ml", o_ml, e.ml);
                chk("pkt_off", o_offset, e.off);
                chk("pkt_overlap", o_overlap, e.ovl);
                chk("pkt_eoj", o_eoj, e.eoj);
                chk("pkt_delim", o_delim, e.delim);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, vs;
        cur = empty_pkt();
        rst_n = 1'b0; i_valid = 1'b0; i_ll = '0; i_ml = '0; i_offset = '0;
        i_overlap_len = '0; i_eoj = 1'b0; i_delim = 1'b0; o_ready = 1'b1;

        for (int k = 0; k < 8; k++)
            tbl[k] = mk(k + 1, k + 17, k + 33, 0, 1'b0, 1'b0, (k % 4 == 3), 4'b1111, 3'd4);
        tbl[8]  = mk(9,  25, 41, 0, 1'b0, 1'b0, 1'b0, 4'b0000, 3'd0);
        tbl[9]  = mk(10, 26, 42, 0, 1'b0, 1'b0, 1'b0, 4'b0000, 3'd0);
        tbl[10] = mk(11, 27, 43, 5, 1'b1, 1'b0, 1'b1, 4'b0111, 3'd3);
        tbl[11] = mk(12, 28, 44, 0, 1'b0, 1'b0, 1'b0, 4'b0000, 3'd0);
        tbl[12] = mk(13, 29, 45, 2, 1'b0, 1'b1, 1'b1, 4'b0011, 3'd2);
        tbl[13] = mk(14, 30, 46, 7, 1'b1, 1'b0, 1'b1, 4'b0001, 3'd1);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_o_valid", o_valid, 0);
        chk("rst_o_mask", o_mask, 0);
        chk("rst_o_count", o_count, 0);
        chk("rst_o_ll", o_ll, 0);
        chk("rst_o_eoj", o_eoj, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_i_ready", i_ready, 1);

        // Full packets at line rate
        stalls = 0;
        rel_cycle.delete();
        for (int k = 0; k < 8; k++) send(tbl[k]);
        wait_drain(50);
        chk("stream_no_backpressure", stalls, 0);
        chk("stream_pkt_num", rel_cycle.size(), 2);
        if (rel_cycle.size() == 2) chk("stream_pkt_spacing", rel_cycle[1] - rel_cycle[0], 4);

        // eoj and delim closes
        for (int k = 8; k < 14; k++) send(tbl[k]);
        wait_drain(50);

        // Stall both buffers and the fifo, then release
        o_ready = 1'b0;
        base = accepted;
        fork
            begin
                repeat (30) @(posedge clk);
                #3;
                chk("stall_accepted", accepted - base, 16);
                chk("stall_i_ready", i_ready, 0);
                chk("stall_o_valid", o_valid, 1);
                chk("stall_first_lane", o_ll[W-1:0], 100);
                o_ready = 1'b1;
            end
            begin
                for (int k = 0; k < 20; k++)
                    send(mk(100 + k, 200 + k, 300 + k, k, 1'b0, 1'b0, (k % 4 == 3), 4'b1111, 3'd4));
            end
        join
        wait_drain(100);

        // Reset with one closed and one filling buffer
        o_ready = 1'b0;
        for (int k = 0; k < 6; k++)
            send(mk(400 + k, 410 + k, 420 + k, 0, 1'b0, 1'b0, (k % 4 == 3), 4'b1111, 3'd4));
        repeat (3) @(posedge clk);
        #1;
        chk("midrst_pre_valid", o_valid, 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_q.delete();
        cur = empty_pkt();
        cur_n = 0;
        chk("midrst_o_valid", o_valid, 0);
        chk("midrst_o_mask", o_mask, 0);
        chk("midrst_i_ready", i_ready, 1);
        chk("midrst_o_ll", o_ll, 0);
        o_ready = 1'b1;
        send(mk(500, 510, 520, 3, 1'b1, 1'b0, 1'b1, 4'b0001, 3'd1));
        wait_drain(50);

`ifdef SEQ_PACKER_TIMEOUT_EN
        send(mk(600, 610, 620, 0, 1'b0, 1'b0, 1'b1, 4'b0001, 3'd1));
        repeat (64) @(posedge clk);
        #1;
        chk("timeout_not_early", o_valid, 0);
        @(posedge clk); #1;
        chk("timeout_flush", o_valid, 1);
        wait_drain(50);
`else
        send(mk(600, 610, 620, 0, 1'b0, 1'b0, 1'b0, 4'b0000, 3'd0));
        vs = valid_seen;
        repeat (1000) @(posedge clk);
        #1;
        chk("no_timeout_pkt", valid_seen - vs, 0);
        chk("no_timeout_valid", o_valid, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
